// File: rtl/acc_wb_sb_pkg.sv
// acc_wb_sb_pkg: shared register-file types and defaults for the writeback/scoreboard slice
package acc_wb_sb_pkg;
    localparam int NUM_REGS_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PEND_W_DEF = 2;
    localparam int AW_DEF = $clog2(NUM_REGS_DEF);
    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef struct packed {
        reg_addr_t tag;
        data_t result;
    } wb_entry_t;
endpackage

// File: rtl/acc_wb_fifo.sv
// acc_wb_fifo: 2-entry result FIFO with registered ready
// ports: clk_i/rst_i; push_i+data_i in (accepted only while ready_o);
//        pop_i removes head_o when not empty_o; ready_o reflects count after the last edge
module acc_wb_fifo
    import acc_wb_sb_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   ready_o,
    output logic   empty_o
);
    entry_t mem [2];
    logic [1:0] count, next_count;
    logic wr_ptr, rd_ptr, push, pop;
    always_comb begin
        push = push_i && ready_o;
        pop = pop_i && count != 2'd0;
        next_count = count + {1'b0, push} - {1'b0, pop};
        head_o = mem[rd_ptr];
        empty_o = count == 2'd0;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            count <= next_count;
            ready_o <= next_count != 2'd2;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/acc_wb_sb.sv
// acc_wb_sb: FPU writeback stage with CPU-priority write port and per-register pending scoreboard
// ports: iss_* issue tracking, fpu_* result input, cpu_wr_* priority write, rf_* write port,
//        rd_addr_i/rf_rdata_i -> rd_data_o/rd_valid_o bypassed read, busy_o, sticky err_o
module acc_wb_sb
    import acc_wb_sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PEND_W = PEND_W_DEF,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_tag_i,
    output logic              iss_ready_o,
    input  logic              fpu_valid_i,
    output logic              fpu_ready_o,
    input  logic [DATA_W-1:0] fpu_result_i,
    input  logic [AW-1:0]     fpu_tag_i,
    input  logic              cpu_wr_valid_i,
    input  logic [AW-1:0]     cpu_wr_addr_i,
    input  logic [DATA_W-1:0] cpu_wr_data_i,
    output logic              rf_wren_o,
    output logic [AW-1:0]     rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              err_o
);
    typedef struct packed {
        logic [AW-1:0] tag;
        logic [DATA_W-1:0] result;
    } entry_t;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    logic [PEND_W-1:0] pend [NUM_REGS];
    entry_t head;
    logic empty, retire, iss_fire, ret_rd, any_pend;
    acc_wb_fifo #(.entry_t(entry_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fpu_valid_i),
        .data_i  ('{tag: fpu_tag_i, result: fpu_result_i}),
        .pop_i   (retire),
        .head_o  (head),
        .ready_o (fpu_ready_o),
        .empty_o (empty)
    );
    always_comb begin
        // buffered results are dropped, not written, when reset lands mid-operation
        retire = !rst_i && !cpu_wr_valid_i && !empty;
        rf_wren_o = cpu_wr_valid_i || retire;
        rf_waddr_o = cpu_wr_valid_i ? cpu_wr_addr_i : head.tag;
        rf_wdata_o = cpu_wr_valid_i ? cpu_wr_data_i : head.result;
        iss_ready_o = pend[iss_tag_i] != PEND_MAX || (retire && head.tag == iss_tag_i);
        iss_fire = iss_valid_i && iss_ready_o;
        ret_rd = retire && head.tag == rd_addr_i && pend[rd_addr_i] == PEND_W'(1);
        rd_valid_o = pend[rd_addr_i] == '0 || ret_rd;
        rd_data_o = ret_rd ? head.result : rf_rdata_i;
        any_pend = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) any_pend = any_pend || pend[r] != '0;
        busy_o = any_pend || !empty;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
        end else begin
            if (retire && pend[head.tag] == '0) err_o <= 1'b1;
            // an orphan retire leaves the counter at zero instead of wrapping
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= pend[r]
                    + PEND_W'(iss_fire && iss_tag_i == AW'(r))
                    - PEND_W'(retire && head.tag == AW'(r) && pend[r] != '0);
        end
    end
endmodule

// File: tb/tb_acc_wb_sb.sv
// tb_acc_wb_sb: table-driven and directed checks of acc_wb_sb
module tb_acc_wb_sb;
    logic clk = 0, rst = 1;
    logic iss_valid, fpu_valid, cpu_v, rf_wren, rd_valid, busy, err, iss_ready, fpu_ready;
    logic [4:0] iss_tag, fpu_tag, cpu_a, rf_waddr, rd_addr;
    logic [31:0] fpu_res, cpu_d, rf_wdata, rf_rdata, rd_data;
    int total = 0, bad = 0;

    acc_wb_sb dut (
        .clk_i(clk), .rst_i(rst),
        .iss_valid_i(iss_valid), .iss_tag_i(iss_tag), .iss_ready_o(iss_ready),
        .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_result_i(fpu_res), .fpu_tag_i(fpu_tag),
        .cpu_wr_valid_i(cpu_v), .cpu_wr_addr_i(cpu_a), .cpu_wr_data_i(cpu_d),
        .rf_wren_o(rf_wren), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .rd_addr_i(rd_addr), .rf_rdata_i(rf_rdata), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cv; logic [4:0] ca; logic [31:0] cd;
        logic fv; logic [4:0] ft; logic [31:0] fr;
        logic iv; logic [4:0] it;
        logic [4:0] ra; logic [31:0] rr;
        logic ew; logic [4:0] ea; logic [31:0] ed;
        logic efr, eir, erv; logic [31:0] erd; logic eb;
    } vec_t;
    vec_t vt [20];

    function automatic vec_t mk(logic cv, logic [4:0] ca, logic [31:0] cd,
                                logic fv, logic [4:0] ft, logic [31:0] fr,
                                logic iv, logic [4:0] it, logic [4:0] ra,
                                logic ew, logic [4:0] ea, logic [31:0] ed,
                                logic efr, logic eir, logic erv, logic [31:0] erd, logic eb);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cd = cd; v.fv = fv; v.ft = ft; v.fr = fr;
        v.iv = iv; v.it = it; v.ra = ra; v.rr = 32'h11;
        v.ew = ew; v.ea = ea; v.ed = ed; v.efr = efr; v.eir = eir; v.erv = erv; v.erd = erd; v.eb = eb;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 0; iss_tag = 0; fpu_valid = 0; fpu_tag = 0; fpu_res = 0;
        cpu_v = 0; cpu_a = 0; cpu_d = 0;
    endtask

    task automatic smp(); @(negedge clk); endtask
    task automatic nxt(); @(posedge clk); #1; endtask

    task automatic apply(input vec_t v, input int i);
        cpu_v = v.cv; cpu_a = v.ca; cpu_d = v.cd;
        fpu_valid = v.fv; fpu_tag = v.ft; fpu_res = v.fr;
        iss_valid = v.iv; iss_tag = v.it; rd_addr = v.ra; rf_rdata = v.rr;
        smp();
        chk($sformatf("row%0d wren", i), {31'b0, rf_wren}, {31'b0, v.ew});
        if (v.ew) begin
            chk($sformatf("row%0d waddr", i), {27'b0, rf_waddr}, {27'b0, v.ea});
            chk($sformatf("row%0d wdata", i), rf_wdata, v.ed);
        end
        chk($sformatf("row%0d fpu_ready", i), {31'b0, fpu_ready}, {31'b0, v.efr});
        chk($sformatf("row%0d iss_ready", i), {31'b0, iss_ready}, {31'b0, v.eir});
        chk($sformatf("row%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, v.erv});
        if (v.erv) chk($sformatf("row%0d rd_data", i), rd_data, v.erd);
        chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, v.eb});
        chk($sformatf("row%0d err", i), {31'b0, err}, 32'd0);
        nxt();
    endtask

    initial begin
        //        cv ca  cd      fv ft fr            iv it ra  ew ea ed            fr ir rv rd            b
        vt[0]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 5,  0, 0, 0,            1, 1, 1, 32'h11,       0);
        vt[1]  = mk(0, 0, 0,     0, 0, 0,            1, 5, 5,  0, 0, 0,            1, 1, 1, 32'h11,       0);
        vt[2]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 5,  0, 0, 0,            1, 1, 0, 0,            1);
        vt[3]  = vt[2];
        vt[4]  = vt[2];
        vt[5]  = mk(0, 0, 0,     1, 5, 32'h3F800000, 0, 0, 5,  0, 0, 0,            1, 1, 0, 0,            1);
        vt[6]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 5,  1, 5, 32'h3F800000, 1, 1, 1, 32'h3F800000, 1);
        vt[7]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 5,  0, 0, 0,            1, 1, 1, 32'h11,       0);
        vt[8]  = mk(0, 0, 0,     1, 3, 32'h33,       1, 3, 3,  0, 0, 0,            1, 1, 1, 32'h11,       0);
        vt[9]  = mk(1, 7, 32'h77, 0, 0, 0,           0, 0, 3,  1, 7, 32'h77,       1, 1, 0, 0,            1);
        vt[10] = mk(1, 7, 32'h78, 0, 0, 0,           0, 0, 3,  1, 7, 32'h78,       1, 1, 0, 0,            1);
        vt[11] = mk(0, 0, 0,     0, 0, 0,            0, 0, 3,  1, 3, 32'h33,       1, 1, 1, 32'h33,       1);
        vt[12] = mk(0, 0, 0,     0, 0, 0,            0, 0, 3,  0, 0, 0,            1, 1, 1, 32'h11,       0);
        vt[13] = mk(1, 10, 32'hA0, 1, 1, 32'h101,    1, 1, 0,  1, 10, 32'hA0,      1, 1, 1, 32'h11,       0);
        vt[14] = mk(1, 10, 32'hA1, 1, 2, 32'h202,    1, 2, 0,  1, 10, 32'hA1,      1, 1, 1, 32'h11,       1);
        vt[15] = mk(1, 10, 32'hA2, 1, 6, 32'h606,    1, 6, 0,  1, 10, 32'hA2,      0, 1, 1, 32'h11,       1);
        vt[16] = mk(0, 0, 0,     1, 6, 32'h606,      0, 0, 0,  1, 1, 32'h101,      0, 1, 1, 32'h11,       1);
        vt[17] = mk(0, 0, 0,     1, 6, 32'h606,      0, 0, 0,  1, 2, 32'h202,      1, 1, 1, 32'h11,       1);
        vt[18] = mk(0, 0, 0,     0, 0, 0,            0, 0, 0,  1, 6, 32'h606,      1, 1, 1, 32'h11,       1);
        vt[19] = mk(0, 0, 0,     0, 0, 0,            0, 0, 0,  0, 0, 0,            1, 1, 1, 32'h11,       0);

        idle(); rd_addr = 0; rf_rdata = 32'h11;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 20; i++) apply(vt[i], i);

        // saturation on tag 9
        idle(); rd_addr = 0;
        for (int k = 0; k < 3; k++) begin
            iss_valid = 1; iss_tag = 9;
            smp(); chk($sformatf("sat issue%0d ready", k), {31'b0, iss_ready}, 32'd1);
            nxt();
        end
        iss_valid = 0; iss_tag = 9;
        smp(); chk("sat full ready", {31'b0, iss_ready}, 32'd0);
        chk("sat busy", {31'b0, busy}, 32'd1);
        nxt();
        iss_valid = 1; fpu_valid = 1; fpu_tag = 9; fpu_res = 32'h900;
        smp(); chk("sat push ready", {31'b0, iss_ready}, 32'd0);
        nxt();
        fpu_valid = 0;
        smp(); chk("sat retire ready", {31'b0, iss_ready}, 32'd1);
        chk("sat retire waddr", {27'b0, rf_waddr}, 32'd9);
        nxt();
        iss_valid = 0;
        smp(); chk("sat still full", {31'b0, iss_ready}, 32'd0);
        nxt();
        for (int k = 0; k < 3; k++) begin
            fpu_valid = 1; fpu_tag = 9; fpu_res = 32'h901 + k;
            nxt();
            fpu_valid = 0;
            nxt();
        end
        smp(); chk("sat drained busy", {31'b0, busy}, 32'd0);
        chk("sat drained err", {31'b0, err}, 32'd0);
        nxt();

        // bypass on tag 4
        idle(); rd_addr = 4; rf_rdata = 32'h55;
        iss_valid = 1; iss_tag = 4;
        smp(); chk("byp pre valid", {31'b0, rd_valid}, 32'd1);
        chk("byp pre data", rd_data, 32'h55);
        nxt();
        idle();
        smp(); chk("byp pending valid", {31'b0, rd_valid}, 32'd0);
        nxt();
        fpu_valid = 1; fpu_tag = 4; fpu_res = 32'h40000000;
        smp(); chk("byp push valid", {31'b0, rd_valid}, 32'd0);
        nxt();
        idle();
        smp(); chk("byp retire valid", {31'b0, rd_valid}, 32'd1);
        chk("byp retire data", rd_data, 32'h40000000);
        chk("byp retire waddr", {27'b0, rf_waddr}, 32'd4);
        nxt();
        smp(); chk("byp post data", rd_data, 32'h55);
        chk("byp post busy", {31'b0, busy}, 32'd0);
        nxt();

        // orphan retire then reset with a full FIFO
        idle(); rd_addr = 0;
        fpu_valid = 1; fpu_tag = 2; fpu_res = 32'h222;
        smp(); chk("err pre", {31'b0, err}, 32'd0);
        nxt();
        idle();
        smp(); chk("err wren", {31'b0, rf_wren}, 32'd1);
        chk("err waddr", {27'b0, rf_waddr}, 32'd2);
        chk("err wdata", rf_wdata, 32'h222);
        chk("err fifo busy", {31'b0, busy}, 32'd1);
        nxt();
        smp(); chk("err sticky", {31'b0, err}, 32'd1);
        nxt();
        cpu_v = 1; cpu_a = 0; cpu_d = 32'hC0;
        fpu_valid = 1; fpu_tag = 11; fpu_res = 32'hB11;
        nxt();
        fpu_tag = 12; fpu_res = 32'hB12;
        nxt();
        fpu_valid = 0;
        smp(); chk("rst full ready", {31'b0, fpu_ready}, 32'd0);
        nxt();
        cpu_v = 0; rst = 1;
        smp(); chk("rst cycle wren", {31'b0, rf_wren}, 32'd0);
        nxt();
        rst = 0;
        smp(); chk("rst after wren", {31'b0, rf_wren}, 32'd0);
        chk("rst after err", {31'b0, err}, 32'd0);
        chk("rst after ready", {31'b0, fpu_ready}, 32'd1);
        chk("rst after busy", {31'b0, busy}, 32'd0);
        nxt();
        smp(); chk("rst later wren", {31'b0, rf_wren}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
